// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: state encoding, digit indices/maxima and helpers for time_set_ctrl
package time_set_ctrl_pkg;
  typedef enum logic [2:0] {RUN, SET_HT, SET_HU, SET_MT, SET_MU} state_t;
  localparam int IDX_HT = 3;
  localparam int IDX_HU = 2;
  localparam int IDX_MT = 1;
  localparam int IDX_MU = 0;
  localparam logic [1:0] MAX_HT = 2'd2;
  localparam logic [3:0] MAX_HU = 4'd9;
  localparam logic [2:0] MAX_MT = 3'd5;
  localparam logic [3:0] MAX_MU = 4'd9;
  localparam logic [3:0] HU_WRAP = 4'd3;
  localparam logic [5:0] PRESCALE_MAX = 6'd59;
  function automatic state_t next_mode(state_t s);
    return (s == SET_MU) ? RUN : state_t'(s + 3'd1);
  endfunction
  function automatic logic [3:0] setting_of(state_t s);
    return (s == SET_HT) ? 4'b1000 :
           (s == SET_HU) ? 4'b0100 :
           (s == SET_MT) ? 4'b0010 :
           (s == SET_MU) ? 4'b0001 : 4'b0000;
  endfunction
endpackage

// File: rtl/time_set_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer with rising-edge detect for a raw button level
module btn_sync_edge (
  input  logic Clk,
  input  logic Clr,
  input  logic btn,
  output logic held,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {btn, s1, s2};
  assign held = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: clock run/set FSM with seconds prescaler, minute carry, 24h wrap and auto-repeat
module time_set_ctrl
  import time_set_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick_1hz,
  input  logic       Mode_btn,
  input  logic       Inc_btn,
  input  logic [1:0] HT,
  input  logic [3:0] HU,
  input  logic [2:0] MT,
  input  logic [3:0] MU,
  output logic [3:0] Up,
  output logic [3:0] LD,
  output logic [3:0] En,
  output logic [3:0] LD_VAL,
  output logic [3:0] Setting
);
  state_t state, state_nx;
  logic [5:0] presc, presc_nx;
  logic [1:0] rpt, rpt_nx;
  logic [3:0] up_nx, ld_nx;
  logic mode_rise, mode_held, inc_rise, inc_held;
  logic wrap_day, c1, c2, c3, inc_act;
  btn_sync_edge u_mode (.Clk(Clk), .Clr(Clr), .btn(Mode_btn), .held(mode_held), .rise(mode_rise));
  btn_sync_edge u_inc (.Clk(Clk), .Clr(Clr), .btn(Inc_btn), .held(inc_held), .rise(inc_rise));
  assign wrap_day = HT == MAX_HT && HU == HU_WRAP;
  assign c1 = MU == MAX_MU;
  assign c2 = c1 && MT == MAX_MT;
  assign c3 = c2 && (HU == MAX_HU || wrap_day);
  assign inc_act = state != RUN && ((inc_rise && !mode_rise) || (Tick_1hz && rpt == 2'd2 && inc_held && !mode_held));
  always_comb begin
    state_nx = mode_rise ? next_mode(state) : state;
    presc_nx = presc;
    rpt_nx = 2'd0;
    up_nx = 4'b0000;
    ld_nx = 4'b0000;
    if (state == RUN && Tick_1hz) begin
      presc_nx = (presc == PRESCALE_MAX) ? 6'd0 : presc + 6'd1;
      if (presc == PRESCALE_MAX) begin
        up_nx[IDX_HT] = c3;
        up_nx[IDX_HU] = c2 && !wrap_day;
        up_nx[IDX_MT] = c1;
        up_nx[IDX_MU] = 1'b1;
        ld_nx[IDX_HU] = c2 && wrap_day;
      end
    end
    if (state == RUN && mode_rise) presc_nx = 6'd0;
    if (state != RUN && inc_held && !mode_held)
      rpt_nx = (Tick_1hz && rpt != 2'd2) ? rpt + 2'd1 : rpt;
    if (inc_act) begin
      up_nx = (state == SET_HU && wrap_day) ? 4'b0000 : setting_of(state);
      ld_nx[IDX_HU] = state == SET_HU && wrap_day;
    end
    // hours beyond 23 are pulled back once the counters are otherwise idle
    if (HT == MAX_HT && HU > HU_WRAP && up_nx == 4'b0000 && ld_nx == 4'b0000 && En == 4'b0000)
      ld_nx[IDX_HU] = 1'b1;
  end
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) begin
      state <= RUN;
      presc <= 6'd0;
      rpt <= 2'd0;
      Up <= 4'b0000;
      LD <= 4'b0000;
      En <= 4'b0000;
      LD_VAL <= 4'b0000;
      Setting <= 4'b0000;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      rpt <= rpt_nx;
      Up <= up_nx;
      LD <= ld_nx;
      En <= up_nx | ld_nx;
      LD_VAL <= 4'b0000;
      Setting <= setting_of(state_nx);
    end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Clk  in  1  system clock; all state changes on rising edge.
REQ-002 Clr  in  1  reset, asynchronous, active-low.
REQ-003 Tick_1hz  in  1  one-Clk-cycle pulse per second.
REQ-004 Mode_btn  in  1  raw level, asynchronous to Clk.
REQ-005 Inc_btn  in  1  raw level, asynchronous to Clk.
REQ-006 HT  in  2  current hours-tens digit (0-2).
REQ-007 HU  in  4  current hours-units digit (0-9).
REQ-008 MT  in  3  current minutes-tens digit (0-5).
REQ-009 MU  in  4  current minutes-units digit (0-9).
REQ-010 Up  out  4  per-digit count pulse; bit 3=HT, 2=HU, 1=MT, 0=MU.
REQ-011 LD  out  4  per-digit load pulse; same bit order.
REQ-012 En  out  4  per-digit enable; En[i] SHALL be high exactly when Up[i] or LD[i] is high.
REQ-013 LD_VAL  out  4  load value for HU and HT; HT uses bits [1:0].
REQ-014 Setting  out  4  one-hot digit under edit; 0000 in RUN.

Function
REQ-015 All outputs SHALL be registered; every Up/LD/En pulse SHALL be exactly one Clk cycle wide.
REQ-016 Each button SHALL pass a 2-flop synchronizer plus rising-edge detect; the resulting action SHALL appear on outputs in the cycle after the 3rd Clk edge at which the button is sampled high.
REQ-017 The FSM states SHALL be RUN, SET_HT, SET_HU, SET_MT, SET_MU; a Mode press SHALL advance RUN->SET_HT->SET_HU->SET_MT->SET_MU->RUN.
REQ-018 In RUN, a 6-bit seconds prescaler SHALL count Tick_1hz pulses 0..59; on the tick at 59 it SHALL wrap to 0 and issue a minute step.
REQ-019 A minute step SHALL pulse Up[0]; it SHALL also pulse Up[1] if MU==9.
REQ-020 A minute step SHALL also pulse Up[2] if MU==9 and MT==5.
REQ-021 A minute step SHALL also pulse Up[3] if MU==9, MT==5 and HU==9.
REQ-022 At 23:59, a minute step SHALL pulse Up[3] (counter wraps 2->0), Up[1] and Up[0], and SHALL issue LD[2] with LD_VAL=0 instead of Up[2].
REQ-023 In any SET state, Tick_1hz SHALL NOT advance the prescaler, and the prescaler SHALL be cleared on entry to SET_HT.
REQ-024 In a SET state, an Inc press SHALL pulse Up of the selected digit only, with no carry.
REQ-025 In SET_HU with HT==2 and HU==3, an Inc press SHALL issue LD[2] with LD_VAL=0 instead of Up[2].
REQ-026 Whenever HT==2 and HU>3, with no other pulse pending, the block SHALL issue LD[2] with LD_VAL=0 one cycle later.
REQ-027 Auto-repeat: if Inc stays held in a SET state across 2 Tick_1hz pulses, every further tick while held SHALL produce one Up of the selected digit.
REQ-028 Mode and Inc edges in the same cycle: Mode SHALL win and Inc SHALL be discarded; Inc in RUN SHALL be ignored.
REQ-029 LD_VAL SHALL be 0 whenever no LD bit is high.

Reset
REQ-030 Clr low SHALL immediately force state RUN, prescaler 0, synchronizer flops 0, auto-repeat counter 0, and Up=LD=En=0000, LD_VAL=0, Setting=0000.
REQ-031 Clr asserted mid-edit or mid-pulse SHALL abort the operation; after release the block SHALL resume in RUN and emit no stale pulse.

Structure
REQ-032 A shared package SHALL hold the state encoding, digit index constants (HT=3, HU=2, MT=1, MU=0), digit maxima (2, 9, 5, 9), and PRESCALE_MAX=59.
REQ-033 The synchronizer and edge detect SHALL be one sub-module, btn_sync_edge, instantiated once per button.
REQ-034 The FSM, prescaler, carry logic and auto-repeat logic SHALL reside in time_set_ctrl.

Verification
REQ-035 Digits 12:59, RUN, prescaler at 59, one tick -> single cycle with Up=0111, LD=0000, En=0111.
REQ-036 Digits 23:59, RUN, prescaler at 59, one tick -> Up=1011, LD=0100, LD_VAL=0, En=1111.
REQ-037 Five Mode presses from RUN -> Setting sequence 1000, 0100, 0010, 0001, 0000; ticks during SET produce no pulses.
REQ-038 SET_HU with HT=2, HU=3, Inc press -> LD=0100, LD_VAL=0; SET_HT with HT=1, HU=7, Inc and counter to 2 -> LD[2] pulse with LD_VAL=0 follows.
REQ-039 Mode and Inc rising together in SET_MT -> state SET_MU, Up=0000; Inc held through 4 ticks in SET_MU -> Up[0] on ticks 3 and 4 only.
REQ-040 Clr pulsed low during Up pulse in SET_MU -> outputs 0 immediately, Setting=0000 after release, no further pulse.
